fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Fetch stage feeding the if_id pipeline register. Owns the PC, issues requests to instruction ROM
//  via a req/ack handshake and presents (if_pc, if_inst, if_valid) to if_id. Honours ID-stage stall
//  and branch redirect. Up to 1 inst/cycle when ROM acks in the request cycle.
// PARAMETERS
//  ADDR_W    32            PC / ROM address width
//  INST_W    32            instruction width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       reset, asynchronous, active-low (RstEnable == 1'b0)
//  rom_req        out  1       ROM request; held with rom_addr stable until rom_ack
//  rom_addr       out  ADDR_W  ROM fetch address
//  rom_ack        in   1       ROM response valid, same cycle or any later cycle after rom_req
//  rom_data       in   INST_W  instruction, valid when rom_ack
//  id_stall       in   1       downstream cannot take the instruction this cycle
//  branch_flag    in   1       one-cycle redirect pulse from ID
//  branch_target  in   ADDR_W  redirect address, valid with branch_flag
//  if_pc          out  ADDR_W  PC of presented instruction
//  if_inst        out  INST_W  presented instruction
//  if_valid       out  1       if_pc/if_inst valid; consumed on if_valid && !id_stall
//  misalign_exc   out  1       only with FETCH_ALIGN_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync use): pc=RESET_PC, rom_req=0, rom_addr=0, if_pc=0, if_inst=0,
//    if_valid=0, kill=0, state=IDLE. Release: IDLE for one cycle, then FETCH.
//  - States: IDLE -> FETCH; FETCH -(ack, slot free)-> FETCH; FETCH -(ack, slot stalled)-> FULL;
//    FULL -(!id_stall)-> FETCH; any state -(branch_flag)-> FETCH at target.
//  - FETCH: rom_req=1, rom_addr=pc. Slot free = !if_valid || !id_stall. On rom_ack with kill=0:
//    if_pc<=pc, if_inst<=rom_data, if_valid<=1 (latency: ack cycle N -> visible N+1), pc<=pc+4
//    (mod 2^ADDR_W; 32'hFFFF_FFFC wraps to 0). rom_req stays 1 next cycle only if slot free.
//  - FETCH with no ack: rom_req/rom_addr held unchanged; no retraction allowed.
//  - FULL: rom_req=0; output held stable while id_stall; no new request issued.
//  - Consume without new data: if_valid && !id_stall && no accepted ack -> if_valid<=0.
//  - Redirect (branch_flag): pc<=branch_target; if_valid<=0 next cycle (flush).
//    Request outstanding, no ack this cycle: kill<=1, rom_addr held; next ack dropped, kill<=0,
//    then rom_addr=target. Ack in same cycle as branch_flag: data dropped, next req at target.
//  - Priority: rst > branch_flag > id_stall > normal advance.
//  - Reset mid-transaction: rom_req drops asynchronously; ROM abandons in-flight request; any
//    ack after reset release before first request is ignored.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: branch_target[1:0]!=0 on redirect -> no ROM request issued,
//   presents if_pc=target, if_inst=NopInst, if_valid=1, misalign_exc=1 (cleared on consume);
//   fetch then stalls in FULL until next branch_flag or reset. misalign_exc resets to 0.
//  Not defined: port absent; target low bits forced to 2'b00 before use.
// STRUCTURE
//  - Shared define.v: RstEnable, RstDisable, ZeroWord, InstAddrBus, InstBus, NopInst,
//    fetch state encodings (IDLE/FETCH/FULL), PC_INC (4).
//  - One sub-module: pc_next_sel (combinational next-PC mux: hold / pc+4 / target).
//  - Top holds PC, FSM, kill flag, output register.
// TESTING
//  1 Reset then ROM acks same cycle: rom_addr 0,4,8,... one/cycle; if_pc 0 visible 2 cycles after release.
//  2 ROM ack delay 3 cycles: rom_req/rom_addr=0x4 stable 3 cycles; if_valid 1-cycle pulses per inst.
//  3 id_stall held 4 cycles with if_pc=0x8: outputs frozen, state FULL, rom_req=0; release -> 0xC next.
//  4 branch_flag target 0x100 while req to 0x10 outstanding: ack for 0x10 dropped, next rom_addr=0x100,
//    if_valid=0 until 0x100 data; simultaneous id_stall ignored.
//  5 RESET_PC=32'hFFFF_FFFC: second fetch at 0x0; rst asserted mid-wait -> rom_req=0 same cycle, all outputs 0.
//  6 FETCH_ALIGN_CHECK_EN, target 0x102: no ROM req, if_inst=NopInst, misalign_exc=1; off: fetch 0x100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants for the fetch stage: reset levels, bus widths, the NOP
// word presented on a misaligned redirect, the fetch FSM encodings, the PC
// increment and the select type used by the next-PC mux.
// Optional feature macro used by the fetch stage: FETCH_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    // addi x0,x0,0 -- harmless filler instruction.
    localparam logic [31:0] NopInst  = 32'h0000_0013;

    localparam int PC_INC = 4;

    // Fetch FSM encodings.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC4   = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC mux for the fetch stage.
// Ports:
//   pc      in   ADDR_W  current PC
//   target  in   ADDR_W  redirect address
//   sel     in   pc_sel_t  hold / pc+4 / target
//   pc_nxt  out  ADDR_W  selected next PC (pc+4 wraps modulo 2^ADDR_W)
// ---------------------------------------------------------------------------
module pc_next_sel
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    input  pc_sel_t           sel,
    output logic [ADDR_W-1:0] pc_nxt
);

    always_comb begin
        pc_nxt = pc;
        case (sel)
            PC_INC4:   pc_nxt = pc + ADDR_W'(PC_INC);
            PC_TARGET: pc_nxt = target;
            default:   pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Fetch stage feeding if_id. Owns the PC, requests instructions from the ROM
// with a req/ack handshake and presents (if_pc, if_inst, if_valid) to ID.
// Handles ID stall and branch redirect; one instruction per cycle when the
// ROM acks in the request cycle.
// Optional: FETCH_ALIGN_CHECK_EN adds misalign_exc and traps misaligned
// redirect targets; without it the target low bits are forced to zero.
// Ports:
//   clk, rst (async, active-low)
//   rom_req/rom_addr out, rom_ack/rom_data in   ROM handshake
//   id_stall in                                 ID cannot accept this cycle
//   branch_flag/branch_target in                redirect pulse from ID
//   if_pc/if_inst/if_valid out                  presented instruction
//   misalign_exc out (FETCH_ALIGN_CHECK_EN only)
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = InstAddrBus,
    parameter int                INST_W   = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [INST_W-1:0] rom_data,
    input  logic              id_stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
`ifdef FETCH_ALIGN_CHECK_EN
   ,output logic              misalign_exc
`endif
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic              kill;

    // Holds an instruction acked while the output slot was stalled, so the
    // ROM response is never lost; released into the slot on leaving FULL.
    logic [ADDR_W-1:0] pend_pc;
    logic [INST_W-1:0] pend_inst;
    logic              pend_valid;

    logic              ack_acc;
    logic              slot_free;
    logic              outstanding;
    logic [ADDR_W-1:0] target_use;
    pc_sel_t           pc_sel;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              halt;
    logic              misaligned;
    assign target_use = branch_target;
    assign misaligned = (branch_target[1:0] != 2'b00);
`else
    assign target_use = branch_target & ~ADDR_W'(3);
`endif

    // An ack only counts while we are actually requesting; stray acks after
    // reset release (before the first request) fall out here.
    assign ack_acc     = rom_req && rom_ack;
    assign outstanding = rom_req && !rom_ack;
    assign slot_free   = !if_valid || !id_stall;

    // The PC only advances on a live accepted ack in FETCH, or on redirect.
    always_comb begin
        pc_sel = PC_HOLD;
        if (branch_flag)
            pc_sel = PC_TARGET;
        else if (state == S_FETCH && ack_acc && !kill)
            pc_sel = PC_INC4;
    end

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc     (pc),
        .target (target_use),
        .sel    (pc_sel),
        .pc_nxt (pc_nxt)
    );

    // Main fetch FSM, ROM handshake and output slot. Redirect outranks stall,
    // which outranks normal advance. A redirect that lands while a request is
    // still waiting cannot retract it, so the request is left up and its
    // eventual ack is discarded via kill.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            if_pc      <= '0;
            if_inst    <= INST_W'(ZeroWord);
            if_valid   <= 1'b0;
            pend_pc    <= '0;
            pend_inst  <= '0;
            pend_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            halt         <= 1'b0;
            misalign_exc <= 1'b0;
`endif
        end else begin
            pc <= pc_nxt;
            if (branch_flag) begin
                if_valid   <= 1'b0;
                pend_valid <= 1'b0;
                kill       <= outstanding;
`ifdef FETCH_ALIGN_CHECK_EN
                if (misaligned) begin
                    halt         <= 1'b1;
                    state        <= S_FULL;
                    if_pc        <= target_use;
                    if_inst      <= INST_W'(NopInst);
                    if_valid     <= 1'b1;
                    misalign_exc <= 1'b1;
                    if (!outstanding)
                        rom_req <= 1'b0;
                end else begin
                    halt         <= 1'b0;
                    misalign_exc <= 1'b0;
                    state        <= S_FETCH;
                    if (!outstanding) begin
                        rom_req  <= 1'b1;
                        rom_addr <= target_use;
                    end
                end
`else
                state <= S_FETCH;
                if (!outstanding) begin
                    rom_req  <= 1'b1;
                    rom_addr <= target_use;
                end
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        state    <= S_FETCH;
                        rom_req  <= 1'b1;
                        rom_addr <= pc;
                    end
                    S_FETCH: begin
                        if (ack_acc) begin
                            if (kill) begin
                                kill     <= 1'b0;
                                rom_req  <= 1'b1;
                                rom_addr <= pc;
                                if (if_valid && !id_stall)
                                    if_valid <= 1'b0;
                            end else if (slot_free) begin
                                if_pc    <= pc;
                                if_inst  <= rom_data;
                                if_valid <= 1'b1;
                                rom_req  <= 1'b1;
                                rom_addr <= pc_nxt;
                            end else begin
                                pend_pc    <= pc;
                                pend_inst  <= rom_data;
                                pend_valid <= 1'b1;
                                rom_req    <= 1'b0;
                                state      <= S_FULL;
                            end
                        end else if (if_valid && !id_stall) begin
                            if_valid <= 1'b0;
                        end
                    end
                    S_FULL: begin
                        if (kill && ack_acc) begin
                            kill    <= 1'b0;
                            rom_req <= 1'b0;
                        end
                        if (!id_stall) begin
                            if (pend_valid) begin
                                if_pc      <= pend_pc;
                                if_inst    <= pend_inst;
                                if_valid   <= 1'b1;
                                pend_valid <= 1'b0;
                                state      <= S_FETCH;
                                rom_req    <= 1'b1;
                                rom_addr   <= pc;
                            end else begin
                                if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                                misalign_exc <= 1'b0;
                                if (!halt) begin
                                    state    <= S_FETCH;
                                    rom_req  <= 1'b1;
                                    rom_addr <= pc;
                                end
`else
                                state    <= S_FETCH;
                                rom_req  <= 1'b1;
                                rom_addr <= pc;
`endif
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit: reset, back-to-back fetch, delayed ack,
// stall, redirect with a killed request, misaligned target, PC wrap from a
// second instance with RESET_PC = 32'hFFFF_FFFC, and reset mid-transaction.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        romReq,  romReqB;
    logic [31:0] romAddr, romAddrB;
    logic        romAck;
    logic [31:0] romData, romDataB;
    logic        idStall;
    logic        branchFlag;
    logic [31:0] branchTarget;
    logic [31:0] ifPc, ifPcB;
    logic [31:0] ifInst, ifInstB;
    logic        ifValid, ifValidB;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalignExc, misalignExcB;
`endif

    int vectors;
    int miscompares;

    localparam logic [31:0] TB_NOP = NopInst;

    // Bench ROM contents: a distinct word per address.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign romData  = romWord(romAddr);
    assign romDataB = romWord(romAddrB);

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .rom_req       (romReq),
        .rom_addr      (romAddr),
        .rom_ack       (romAck),
        .rom_data      (romData),
        .id_stall      (idStall),
        .branch_flag   (branchFlag),
        .branch_target (branchTarget),
        .if_pc         (ifPc),
        .if_inst       (ifInst),
        .if_valid      (ifValid)
`ifdef FETCH_ALIGN_CHECK_EN
       ,.misalign_exc  (misalignExc)
`endif
    );

    // Second instance: always-acking ROM, used for the PC wrap case.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk           (clk),
        .rst           (rst),
        .rom_req       (romReqB),
        .rom_addr      (romAddrB),
        .rom_ack       (1'b1),
        .rom_data      (romDataB),
        .id_stall      (1'b0),
        .branch_flag   (1'b0),
        .branch_target (32'h0),
        .if_pc         (ifPcB),
        .if_inst       (ifInstB),
        .if_valid      (ifValidB)
`ifdef FETCH_ALIGN_CHECK_EN
       ,.misalign_exc  (misalignExcB)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change at the falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic ack, input logic stall,
                                 input logic br, input logic [31:0] tgt);
        romAck       = ack;
        idStall      = stall;
        branchFlag   = br;
        branchTarget = tgt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = RstEnable;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst_req",   32'(romReq),   32'h0);
        checkOutput("rst_addr",  romAddr,       32'h0);
        checkOutput("rst_valid", 32'(ifValid),  32'h0);
        checkOutput("rst_pc",    ifPc,          32'h0);
        checkOutput("rst_inst",  ifInst,        32'h0);
        checkOutput("rstB_req",  32'(romReqB),  32'h0);
        rst = RstDisable;

        // Back-to-back fetch with same-cycle ack
        nextCycle();
        checkOutput("t1_req",    32'(romReq),   32'h1);
        checkOutput("t1_addr0",  romAddr,       32'h0);
        checkOutput("t1_valid0", 32'(ifValid),  32'h0);
        checkOutput("wrap_addr0", romAddrB,     32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t1_valid1", 32'(ifValid),  32'h1);
        checkOutput("t1_pc0",    ifPc,          32'h0);
        checkOutput("t1_inst0",  ifInst,        romWord(32'h0));
        checkOutput("t1_addr4",  romAddr,       32'h4);
        checkOutput("wrap_addr1", romAddrB,     32'h0);
        checkOutput("wrap_pc0",  ifPcB,         32'hFFFF_FFFC);
        nextCycle();
        checkOutput("t1_pc4",    ifPc,          32'h4);
        checkOutput("t1_addr8",  romAddr,       32'h8);
        checkOutput("wrap_pc1",  ifPcB,         32'h0);

        // Ack delayed three cycles: request held, valid pulses once
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("t2_req",   32'(romReq),  32'h1);
            checkOutput("t2_addr",  romAddr,      32'h8);
            checkOutput("t2_valid", 32'(ifValid), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t2_pc8",    ifPc,          32'h8);
        checkOutput("t2_valid1", 32'(ifValid),  32'h1);
        checkOutput("t2_addrC",  romAddr,       32'hC);

        // Stall four cycles with if_pc=0x8 on the slot
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput("t3_pc",    ifPc,         32'h8);
            checkOutput("t3_valid", 32'(ifValid), 32'h1);
            checkOutput("t3_req",   32'(romReq),  32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t3_pcC",    ifPc,          32'hC);
        checkOutput("t3_instC",  ifInst,        romWord(32'hC));
        checkOutput("t3_req1",   32'(romReq),   32'h1);
        checkOutput("t3_addr10", romAddr,       32'h10);

        // Redirect to 0x100 while 0x10 is outstanding, stall ignored
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        nextCycle();
        checkOutput("t4_flush",  32'(ifValid),  32'h0);
        checkOutput("t4_held",   romAddr,       32'h10);
        checkOutput("t4_req",    32'(romReq),   32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t4_drop",   32'(ifValid),  32'h0);
        checkOutput("t4_addr",   romAddr,       32'h100);
        nextCycle();
        checkOutput("t4_pc",     ifPc,          32'h100);
        checkOutput("t4_inst",   ifInst,        romWord(32'h100));
        checkOutput("t4_valid",  32'(ifValid),  32'h1);

        // Misaligned redirect to 0x102 while 0x104 is outstanding
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h102);
        nextCycle();
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("t6_pc",     ifPc,              32'h102);
        checkOutput("t6_inst",   ifInst,            TB_NOP);
        checkOutput("t6_exc",    32'(misalignExc),  32'h1);
        checkOutput("t6_valid",  32'(ifValid),      32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t6_noreq",  32'(romReq),       32'h0);
        checkOutput("t6_exc_h",  32'(misalignExc),  32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t6_consume", 32'(ifValid),     32'h0);
        checkOutput("t6_exc_clr", 32'(misalignExc), 32'h0);
        checkOutput("t6_stuck",  32'(romReq),       32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
        nextCycle();
        checkOutput("t6_recover", romAddr,          32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
`else
        checkOutput("t6_flush",  32'(ifValid),  32'h0);
        checkOutput("t6_held",   romAddr,       32'h104);
        checkOutput("t6_nop_ok", TB_NOP ^ ifInst ^ ifInst, 32'h0000_0013);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t6_aligned", romAddr,      32'h100);
        nextCycle();
        checkOutput("t6_pc",     ifPc,          32'h100);
        checkOutput("t6_valid",  32'(ifValid),  32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("t6_wait",   romAddr,       32'h104);
`endif

        // Reset asserted while a request waits for its ack
        checkOutput("t5_pre_req", 32'(romReq),  32'h1);
        #2;
        rst = RstEnable;
        #1;
        checkOutput("t5_req",    32'(romReq),   32'h0);
        checkOutput("t5_addr",   romAddr,       32'h0);
        checkOutput("t5_valid",  32'(ifValid),  32'h0);
        checkOutput("t5_pc",     ifPc,          32'h0);
        checkOutput("t5_inst",   ifInst,        32'h0);
        checkOutput("t5_reqB",   32'(romReqB),  32'h0);

        // Stray ack right after release must not load anything
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        rst = RstDisable;
        nextCycle();
        checkOutput("t5_stray_valid", 32'(ifValid), 32'h0);
        checkOutput("t5_first_addr",  romAddr,      32'h0);
        nextCycle();
        checkOutput("t5_first_pc",    ifPc,         32'h0);
        checkOutput("t5_first_valid", 32'(ifValid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
